// File: rtl/fetch_entry_queue_if.sv
// Fetch-to-decode entry queue bus: producer push side, decode head side, flush and occupancy.
// The queue instance connects to the slave modport; whatever drives and consumes entries connects to master.
interface fetch_entry_queue_if #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush_i;
  logic             push_valid_i;
  logic             push_ready_o;
  logic [63:0]      push_address_i;
  logic [31:0]      push_instruction_i;
  logic             push_bp_valid_i;
  logic [63:0]      push_bp_target_i;
  logic             push_ex_valid_i;
  logic [63:0]      push_ex_cause_i;
  logic             fetch_entry_valid_o;
  logic             fetch_ack_i;
  logic [63:0]      fetch_address_o;
  logic [31:0]      fetch_instruction_o;
  logic             fetch_bp_valid_o;
  logic [63:0]      fetch_bp_target_o;
  logic             fetch_ex_valid_o;
  logic [63:0]      fetch_ex_cause_o;
  logic [ID_W-1:0]  fetch_id_o;
  logic [CNT_W-1:0] count_o;

  modport master (
    output flush_i, push_valid_i, push_address_i, push_instruction_i,
           push_bp_valid_i, push_bp_target_i, push_ex_valid_i, push_ex_cause_i, fetch_ack_i,
    input  push_ready_o, fetch_entry_valid_o, fetch_address_o, fetch_instruction_o,
           fetch_bp_valid_o, fetch_bp_target_o, fetch_ex_valid_o, fetch_ex_cause_o,
           fetch_id_o, count_o
  );

  modport slave (
    input  flush_i, push_valid_i, push_address_i, push_instruction_i,
           push_bp_valid_i, push_bp_target_i, push_ex_valid_i, push_ex_cause_i, fetch_ack_i,
    output push_ready_o, fetch_entry_valid_o, fetch_address_o, fetch_instruction_o,
           fetch_bp_valid_o, fetch_bp_target_o, fetch_ex_valid_o, fetch_ex_cause_o,
           fetch_id_o, count_o
  );
endinterface

// File: rtl/fetch_entry_queue.sv
// First-word fall-through circular queue of fetched instructions between fetch and decode.
// Every entry carries a wrapping sequence id; flush empties the queue but keeps the id counter.
module fetch_entry_queue #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  fetch_entry_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [63:0]     address;
    logic [31:0]     instruction;
    logic            bp_valid;
    logic [63:0]     bp_target;
    logic            ex_valid;
    logic [63:0]     ex_cause;
    logic [ID_W-1:0] id;
  } entry_t;

  entry_t           mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [ID_W-1:0]  seq_r;

  logic   ready_s;
  logic   valid_s;
  logic   push_s;
  logic   pop_s;
  entry_t wr_entry_s;
  entry_t head_s;

  assign ready_s = (count_r < CNT_W'(DEPTH));
  assign valid_s = (count_r != CNT_W'(0));
  assign push_s  = q.push_valid_i && ready_s && !q.flush_i;
  assign pop_s   = q.fetch_ack_i && valid_s && !q.flush_i;

  assign wr_entry_s = '{address:     q.push_address_i,
                        instruction: q.push_instruction_i,
                        bp_valid:    q.push_bp_valid_i,
                        bp_target:   q.push_bp_target_i,
                        ex_valid:    q.push_ex_valid_i,
                        ex_cause:    q.push_ex_cause_i,
                        id:          seq_r};

  // Storage is never reset: only entries covered by count_r are ever presented.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_entry_s;
    end
  end

  // Pointer, occupancy and sequence-id bookkeeping; flush realigns the read pointer onto the write pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_r <= PTR_W'(0);
      wr_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      seq_r    <= ID_W'(0);
    end else if (q.flush_i) begin
      rd_ptr_r <= wr_ptr_r;
      count_r  <= CNT_W'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        seq_r    <= seq_r + ID_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head entry falls through from storage, zeroed while empty so stale data never leaks out.
  always_comb begin
    if (valid_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = '0;
    end
  end

  assign q.push_ready_o        = ready_s;
  assign q.fetch_entry_valid_o = valid_s;
  assign q.fetch_address_o     = head_s.address;
  assign q.fetch_instruction_o = head_s.instruction;
  assign q.fetch_bp_valid_o    = head_s.bp_valid;
  assign q.fetch_bp_target_o   = head_s.bp_target;
  assign q.fetch_ex_valid_o    = head_s.ex_valid;
  assign q.fetch_ex_cause_o    = head_s.ex_cause;
  assign q.fetch_id_o          = head_s.id;
  assign q.count_o             = count_r;
endmodule

// File: tb/tb_fetch_entry_queue.sv
// Directed bench for fetch_entry_queue: a queue-based model checked every cycle plus literal spot checks.
module tb_fetch_entry_queue;
  localparam int DEPTH = 4;
  localparam int ID_W  = 4;

  typedef struct {
    logic [63:0]     addr;
    logic [31:0]     instr;
    logic            bp_valid;
    logic [63:0]     bp_target;
    logic            ex_valid;
    logic [63:0]     ex_cause;
    logic [ID_W-1:0] id;
  } ent_t;

  logic clk;
  logic rst;
  ent_t mq[$];
  logic [ID_W-1:0] seq;
  int ntests;
  int nfail;
  bit chk_en;

  fetch_entry_queue_if #(.DEPTH(DEPTH), .ID_W(ID_W)) bus ();

  fetch_entry_queue #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .q     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [63:0] addr);
    ent_t e;
    e.addr      = addr;
    e.instr     = addr[31:0] ^ 32'hdead_beef;
    e.bp_valid  = addr[2];
    e.bp_target = addr + 64'h100;
    e.ex_valid  = addr[3];
    e.ex_cause  = addr >> 2;
    e.id        = '0;
    return e;
  endfunction

  // One clock: drive inputs, let the DUT take the edge, apply the same rules to the model.
  task automatic step(input logic pv, input logic [63:0] addr, input logic ack, input logic flush);
    ent_t e;
    int   sz;
    e = mk(addr);
    bus.push_valid_i       = pv;
    bus.push_address_i     = e.addr;
    bus.push_instruction_i = e.instr;
    bus.push_bp_valid_i    = e.bp_valid;
    bus.push_bp_target_i   = e.bp_target;
    bus.push_ex_valid_i    = e.ex_valid;
    bus.push_ex_cause_i    = e.ex_cause;
    bus.fetch_ack_i        = ack;
    bus.flush_i            = flush;
    @(posedge clk);
    sz = mq.size();
    if (flush) begin
      mq.delete();
    end else begin
      if (ack && sz > 0) void'(mq.pop_front());
      if (pv && sz < DEPTH) begin
        e.id = seq;
        mq.push_back(e);
        seq = seq + 1'b1;
      end
    end
    #1;
    bus.push_valid_i = 1'b0;
    bus.fetch_ack_i  = 1'b0;
    bus.flush_i      = 1'b0;
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear before any further edge.
  task automatic pulse_reset(input string tag);
    #1 rst = 1'b1;
    mq.delete();
    seq = '0;
    #1;
    chk({tag, "_valid"}, 64'(bus.fetch_entry_valid_o), 64'd0);
    chk({tag, "_count"}, 64'(bus.count_o), 64'd0);
    chk({tag, "_ready"}, 64'(bus.push_ready_o), 64'd1);
    chk({tag, "_id"}, 64'(bus.fetch_id_o), 64'd0);
    #1 rst = 1'b0;
  endtask

  // Every cycle: status and head fields against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", 64'(bus.fetch_entry_valid_o), 64'(mq.size() != 0));
      chk("m_ready", 64'(bus.push_ready_o), 64'(mq.size() < DEPTH));
      chk("m_count", 64'(bus.count_o), 64'(mq.size()));
      if (mq.size() != 0) begin
        chk("m_addr", bus.fetch_address_o, mq[0].addr);
        chk("m_instr", 64'(bus.fetch_instruction_o), 64'(mq[0].instr));
        chk("m_bpv", 64'(bus.fetch_bp_valid_o), 64'(mq[0].bp_valid));
        chk("m_bpt", bus.fetch_bp_target_o, mq[0].bp_target);
        chk("m_exv", 64'(bus.fetch_ex_valid_o), 64'(mq[0].ex_valid));
        chk("m_exc", bus.fetch_ex_cause_o, mq[0].ex_cause);
        chk("m_id", 64'(bus.fetch_id_o), 64'(mq[0].id));
      end
    end
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    ntests = 0;
    nfail = 0;
    chk_en = 1'b0;
    seq = '0;
    bus.flush_i = 1'b0;
    bus.push_valid_i = 1'b0;
    bus.push_address_i = '0;
    bus.push_instruction_i = '0;
    bus.push_bp_valid_i = 1'b0;
    bus.push_bp_target_i = '0;
    bus.push_ex_valid_i = 1'b0;
    bus.push_ex_cause_i = '0;
    bus.fetch_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_valid", 64'(bus.fetch_entry_valid_o), 64'd0);
    chk("rst_ready", 64'(bus.push_ready_o), 64'd1);
    chk("rst_count", 64'(bus.count_o), 64'd0);
    chk("rst_id", 64'(bus.fetch_id_o), 64'd0);
    chk_en = 1'b1;

    // three pushes, then three acks in order
    step(1'b1, 64'h1000, 1'b0, 1'b0);
    step(1'b1, 64'h1004, 1'b0, 1'b0);
    step(1'b1, 64'h1008, 1'b0, 1'b0);
    chk("t1_count", 64'(bus.count_o), 64'd3);
    chk("t1_head", bus.fetch_address_o, 64'h1000);
    chk("t1_id", 64'(bus.fetch_id_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t1_pop_addr", bus.fetch_address_o, 64'h1000 + 64'(4 * i));
      chk("t1_pop_id", 64'(bus.fetch_id_o), 64'(i));
      step(1'b0, 64'h0, 1'b1, 1'b0);
    end
    chk("t1_empty", 64'(bus.fetch_entry_valid_o), 64'd0);

    // full queue: push with ack is refused, retried push lands next cycle
    for (int i = 0; i < DEPTH; i++) step(1'b1, 64'h2000 + 64'(4 * i), 1'b0, 1'b0);
    chk("t2_ready", 64'(bus.push_ready_o), 64'd0);
    chk("t2_full", 64'(bus.count_o), 64'd4);
    step(1'b1, 64'h2100, 1'b1, 1'b0);
    chk("t2_no_write", 64'(bus.count_o), 64'd3);
    step(1'b1, 64'h2100, 1'b0, 1'b0);
    chk("t2_retry", 64'(bus.count_o), 64'd4);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    chk("t2_two_left", 64'(bus.count_o), 64'd2);

    // steady push+ack across pointer wrap
    for (int i = 0; i < 10; i++) step(1'b1, 64'h3000 + 64'(4 * i), 1'b1, 1'b0);
    chk("t3_count", 64'(bus.count_o), 64'd2);
    chk("t3_head", bus.fetch_address_o, 64'h3020);

    // flush with push and ack; sequence id survives
    step(1'b1, 64'h4000, 1'b0, 1'b0);
    chk("t4_count3", 64'(bus.count_o), 64'd3);
    step(1'b1, 64'h4004, 1'b1, 1'b1);
    chk("t4_flush_count", 64'(bus.count_o), 64'd0);
    chk("t4_flush_valid", 64'(bus.fetch_entry_valid_o), 64'd0);
    step(1'b1, 64'h5000, 1'b0, 1'b0);
    chk("t4_next_id", 64'(bus.fetch_id_o), 64'd3);
    chk("t4_next_addr", bus.fetch_address_o, 64'h5000);
    step(1'b0, 64'h0, 1'b1, 1'b0);

    // id wrap over 20 pushes, then reset with an entry still queued
    pulse_reset("t5_rst");
    step(1'b1, 64'h6000, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) begin
      step(1'b1, 64'h6000 + 64'(4 * i), 1'b1, 1'b0);
      if (i == 16) begin
        chk("t5_wrap_id", 64'(bus.fetch_id_o), 64'd0);
        chk("t5_wrap_addr", bus.fetch_address_o, 64'h6040);
      end
    end
    chk("t5_pre_rst_valid", 64'(bus.fetch_entry_valid_o), 64'd1);
    pulse_reset("t5_mid_rst");
    step(1'b0, 64'h0, 1'b0, 1'b0);
    step(1'b1, 64'h7000, 1'b0, 1'b0);
    chk("t5_post_rst_id", 64'(bus.fetch_id_o), 64'd0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
